// File: rtl/jt900h_muldiv_pkg.sv
// Shared definitions for the JT900H multiply/divide unit: operation encodings,
// FSM state type and small operation-decode helpers.
package jt900h_muldiv_pkg;

  localparam logic [1:0] MUL_OP  = 2'd0;
  localparam logic [1:0] MULS_OP = 2'd1;
  localparam logic [1:0] DIV_OP  = 2'd2;
  localparam logic [1:0] DIVS_OP = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StFix
  } state_e;

  // op[1] selects divide, op[0] selects signed operands
  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/jt900h_muldiv_step.sv
// One combinational iteration of the shared engine.
// MUL: radix-2 shift-add on a {high, multiplier} accumulator.
// DIV: restoring step on a {partial remainder, dividend/quotient} accumulator;
//      the quotient bit is returned separately and merged into bit 0 by the caller.
module jt900h_muldiv_step #(
  parameter int unsigned W = 16
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   opnd,
  input  logic           div,
  output logic [2*W-1:0] acc_nxt,
  output logic           qbit
);

  logic [W:0]   sum;
  logic [W:0]   part;
  logic [W-1:0] rem_nxt;

  // Select between the add-and-shift and the compare-subtract-shift step
  always_comb begin
    sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    part    = {acc[2*W-1:W], acc[W-1]};
    qbit    = 1'b0;
    rem_nxt = part[W-1:0];
    if (div) begin
      qbit = (part >= {1'b0, opnd});
      // After a successful subtract the difference is below the divisor, so W bits suffice
      if (qbit) rem_nxt = W'(part - {1'b0, opnd});
      acc_nxt = {rem_nxt, acc[W-2:0], 1'b0};
    end else begin
      acc_nxt = {sum, acc[W-1:1]};
    end
  end

endmodule

// File: rtl/jt900h_muldiv.sv
// JT900H shared sequential multiply/divide unit (MUL, MULS, DIV, DIVS).
// IDLE -> ITER (W cen cycles) -> FIX (1 cen cycle) -> IDLE; done pulses on leaving FIX.
// Optional build macro JT900H_MULDIV_DIV0_EN: a divide by zero skips ITER entirely.
module jt900h_muldiv
  import jt900h_muldiv_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [2*W-1:0] a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] rslt,
  output logic           v,
  output logic           z,
  output logic           s
);

  localparam int unsigned   CW        = $clog2(W) + 1;
  localparam logic [CW-1:0] LastIter  = CW'(W - 1);
  localparam logic [W-1:0]  HalfRange = {1'b1, {(W-1){1'b0}}};

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     op_q, op_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [W-1:0]   alo_q, alo_d;
  logic           neg_res_q, neg_res_d;
  logic           neg_rem_q, neg_rem_d;
  logic           hi_ovf_q, hi_ovf_d;
  logic           div0_q, div0_d;
  logic [2*W-1:0] rslt_q, rslt_d;
  logic           done_q, done_d;
  logic           v_q, v_d, z_q, z_d, s_q, s_d;

  logic           sa, sb;
  logic [2*W-1:0] a_ext, a_mag;
  logic [W-1:0]   b_mag;
  logic [2*W-1:0] step_acc;
  logic           step_qbit;
  logic [W-1:0]   quot, rem, quot_fix, rem_fix;
  logic           q_ovf;
  logic [2*W-1:0] fix_rslt;
  logic           fix_v;

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign rslt = rslt_q;
  assign v    = v_q;
  assign z    = z_q;
  assign s    = s_q;

  // Operand signs and magnitudes; MULS treats a[W-1:0] as the signed multiplicand
  always_comb begin
    sa = 1'b0;
    if (op == MULS_OP)      sa = a[W-1];
    else if (op == DIVS_OP) sa = a[2*W-1];
    sb    = is_signed_op(op) & b[W-1];
    a_ext = is_div(op) ? a : {{W{sa}}, a[W-1:0]};
    a_mag = sa ? (~a_ext + 1'b1) : a_ext;
    b_mag = sb ? (~b + 1'b1) : b;
  end

  jt900h_muldiv_step #(
    .W(W)
  ) u_step (
    .acc     (acc_q),
    .opnd    (opnd_q),
    .div     (is_div(op_q)),
    .acc_nxt (step_acc),
    .qbit    (step_qbit)
  );

  // Sign correction, overflow and divide-by-zero handling applied in FIX
  always_comb begin
    quot     = acc_q[W-1:0];
    rem      = acc_q[2*W-1:W];
    quot_fix = neg_res_q ? (~quot + 1'b1) : quot;
    rem_fix  = neg_rem_q ? (~rem + 1'b1) : rem;
    // Magnitude limit: -2^(W-1) is representable, +2^(W-1) is not
    q_ovf    = neg_res_q ? (quot > HalfRange) : (quot >= HalfRange);
    fix_v    = 1'b0;
    if (!is_div(op_q)) begin
      fix_rslt = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    end else if (div0_q) begin
      fix_rslt = {alo_q, {W{1'b1}}};
      fix_v    = 1'b1;
    end else if (hi_ovf_q || (is_signed_op(op_q) && q_ovf)) begin
      fix_rslt = acc_q;
      fix_v    = 1'b1;
    end else begin
      fix_rslt = {rem_fix, quot_fix};
    end
  end

  // FSM next state, operand capture, iteration and result update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    alo_d     = alo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_ovf_d  = hi_ovf_q;
    div0_d    = div0_q;
    rslt_d    = rslt_q;
    v_d       = v_q;
    z_d       = z_q;
    s_d       = s_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d      = op;
          alo_d     = a[W-1:0];
          neg_res_d = sa ^ sb;
          neg_rem_d = sa;
          div0_d    = is_div(op) && (b == '0);
          // Quotient cannot fit W bits when the dividend's high half reaches the divisor
          hi_ovf_d  = (a_mag[2*W-1:W] >= b_mag);
          cnt_d     = '0;
          if (is_div(op)) begin
            acc_d  = a_mag;
            opnd_d = b_mag;
          end else begin
            acc_d  = {{W{1'b0}}, b_mag};
            opnd_d = a_mag[W-1:0];
          end
`ifdef JT900H_MULDIV_DIV0_EN
          state_d = (is_div(op) && (b == '0)) ? StFix : StIter;
`else
          state_d = StIter;
`endif
        end
      end
      StIter: begin
        acc_d = step_acc | {{(2*W-1){1'b0}}, step_qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIter) state_d = StFix;
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        rslt_d  = fix_rslt;
        v_d     = fix_v;
        z_d     = (fix_rslt == '0);
        s_d     = fix_rslt[2*W-1];
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; everything holds while cen is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= MUL_OP;
      acc_q     <= '0;
      opnd_q    <= '0;
      alo_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_ovf_q  <= 1'b0;
      div0_q    <= 1'b0;
      rslt_q    <= '0;
      done_q    <= 1'b0;
      v_q       <= 1'b0;
      z_q       <= 1'b0;
      s_q       <= 1'b0;
    end else if (cen) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      alo_q     <= alo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_ovf_q  <= hi_ovf_d;
      div0_q    <= div0_d;
      rslt_q    <= rslt_d;
      done_q    <= done_d;
      v_q       <= v_d;
      z_q       <= z_d;
      s_q       <= s_d;
    end
  end

endmodule

// File: tb/tb_jt900h_muldiv.sv
// Self-checking bench for jt900h_muldiv (W=16): directed vectors, randomized
// operations against an arithmetic reference model, cen toggling, start while
// busy and asynchronous reset mid-operation.
module tb_jt900h_muldiv;
  import jt900h_muldiv_pkg::*;

  localparam int W = 16;
`ifdef JT900H_MULDIV_DIV0_EN
  localparam bit Div0En = 1'b1;
`else
  localparam bit Div0En = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cen;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] rslt;
  logic        v;
  logic        z;
  logic        s;

  int n_chk  = 0;
  int n_pass = 0;

  jt900h_muldiv #(
    .W(W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .rslt  (rslt),
    .v     (v),
    .z     (z),
    .s     (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model from the arithmetic definition of each operation
  function automatic void model(input logic [1:0] o, input logic [31:0] aa, input logic [15:0] bb,
                                output logic [31:0] r, output logic vv);
    longint p, q, rm, x, y;
    r  = 32'h0;
    vv = 1'b0;
    if (o == MUL_OP) begin
      p = longint'(aa[15:0]) * longint'(bb);
      r = p[31:0];
    end else if (o == MULS_OP) begin
      p = longint'($signed(aa[15:0])) * longint'($signed(bb));
      r = p[31:0];
    end else if (bb == 16'h0) begin
      vv = 1'b1;
      r  = {aa[15:0], 16'hFFFF};
    end else begin
      if (o == DIV_OP) begin
        x = longint'(aa);
        y = longint'(bb);
      end else begin
        x = longint'($signed(aa));
        y = longint'($signed(bb));
      end
      q  = x / y;
      rm = x % y;
      if ((o == DIV_OP && q > 65535) || (o == DIVS_OP && (q < -32768 || q > 32767))) vv = 1'b1;
      else r = {rm[15:0], q[15:0]};
    end
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [15:0] bb);
    return (Div0En && o == DIV_OP && bb == 16'h0) || (Div0En && o == DIVS_OP && bb == 16'h0)
           ? 2 : W + 2;
  endfunction

  // Issue one operation; lat counts cen edges including the accepting one
  task automatic run_op(input logic [1:0] o, input logic [31:0] aa, input logic [15:0] bb,
                        input bit tog, output logic [31:0] r, output logic vv, output logic zz,
                        output logic ss, output int lat, output bit to);
    bit c;
    op    = o;
    a     = aa;
    b     = bb;
    cen   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    to    = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (done) begin
        to = 1'b0;
        break;
      end
      if (tog) cen = 1'($urandom_range(1, 0));
      c = cen;
      tick();
      if (c) lat++;
    end
    cen = 1'b1;
    r   = rslt;
    vv  = v;
    zz  = z;
    ss  = s;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cen   = 1'b1;
    start = 1'b0;
    op    = MUL_OP;
    a     = 32'h0;
    b     = 16'h0;
    repeat (3) tick();
    n_chk++;
    if ({busy, done, v, z, s} !== 5'b0 || rslt !== 32'h0)
      $display("FAIL reset_state got busy=%b done=%b v=%b z=%b s=%b rslt=%h want all zero",
               busy, done, v, z, s, rslt);
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [31:0] r;
    logic vv, zz, ss;
    int lat;
    bit to;

    run_op(MUL_OP, 32'h0000_00FF, 16'h0101, 1'b0, r, vv, zz, ss, lat, to);
    n_chk++;
    if (to || r !== 32'h0000_FFFF || {vv, zz, ss} !== 3'b000)
      $display("FAIL mul_basic got to=%0d rslt=%h vzs=%b%b%b want rslt=0000ffff vzs=000",
               to, r, vv, zz, ss);
    else n_pass++;
    n_chk++;
    if (lat != 18) $display("FAIL mul_latency got %0d want 18", lat);
    else n_pass++;
    tick();
    n_chk++;
    if (done !== 1'b0) $display("FAIL done_one_cycle got done=%b want 0", done);
    else n_pass++;

    run_op(MULS_OP, 32'h0000_FFFE, 16'h0003, 1'b0, r, vv, zz, ss, lat, to);
    n_chk++;
    if (r !== 32'hFFFF_FFFA || vv !== 1'b0 || ss !== 1'b1 || zz !== 1'b0)
      $display("FAIL muls_basic got rslt=%h v=%b s=%b z=%b want fffffffa v=0 s=1 z=0",
               r, vv, ss, zz);
    else n_pass++;

    run_op(DIV_OP, 32'h0001_0005, 16'h0010, 1'b0, r, vv, zz, ss, lat, to);
    n_chk++;
    if (r !== 32'h0005_1000 || vv !== 1'b0)
      $display("FAIL div_basic got rslt=%h v=%b want 00051000 v=0", r, vv);
    else n_pass++;

    run_op(DIVS_OP, 32'hFFFF_FFF9, 16'h0002, 1'b0, r, vv, zz, ss, lat, to);
    n_chk++;
    if (r !== 32'hFFFF_FFFD || vv !== 1'b0 || ss !== 1'b1)
      $display("FAIL divs_basic got rslt=%h v=%b s=%b want fffffffd v=0 s=1", r, vv, ss);
    else n_pass++;

    run_op(DIV_OP, 32'h0010_0000, 16'h0001, 1'b0, r, vv, zz, ss, lat, to);
    n_chk++;
    if (vv !== 1'b1) $display("FAIL div_overflow got v=%b want 1", vv);
    else n_pass++;

    run_op(DIV_OP, 32'h1234_5678, 16'h0000, 1'b0, r, vv, zz, ss, lat, to);
    n_chk++;
    if (r !== 32'h5678_FFFF || vv !== 1'b1)
      $display("FAIL div_by_zero got rslt=%h v=%b want 5678ffff v=1", r, vv);
    else n_pass++;
    n_chk++;
    if (lat != (Div0En ? 2 : 18))
      $display("FAIL div0_latency got %0d want %0d", lat, Div0En ? 2 : 18);
    else n_pass++;

    run_op(DIVS_OP, 32'hFFFF_8000, 16'h0001, 1'b0, r, vv, zz, ss, lat, to);
    n_chk++;
    if (r !== 32'h0000_8000 || vv !== 1'b0)
      $display("FAIL divs_min_quot got rslt=%h v=%b want 00008000 v=0", r, vv);
    else n_pass++;

    run_op(DIVS_OP, 32'h0000_8000, 16'h0001, 1'b0, r, vv, zz, ss, lat, to);
    n_chk++;
    if (vv !== 1'b1) $display("FAIL divs_pos_overflow got v=%b want 1", vv);
    else n_pass++;
  endtask

  task automatic test_random(input int n, input bit tog);
    logic [1:0] o;
    logic [31:0] aa, r, er, rnd;
    logic [15:0] bb;
    logic vv, zz, ss, ev;
    int lat;
    bit to;
    for (int i = 0; i < n; i++) begin
      o   = 2'($urandom_range(3, 0));
      aa  = $urandom;
      bb  = 16'($urandom);
      rnd = $urandom;
      if (rnd[3:0] == 4'd0) bb = 16'h0;
      else if (o == DIV_OP && rnd[5:4] != 2'd0) aa[31:16] = 16'($urandom_range(32'(bb) - 1, 0));
      else if (o == DIVS_OP && rnd[5:4] != 2'd0) aa = {{12{rnd[31]}}, rnd[31:12]};
      run_op(o, aa, bb, tog, r, vv, zz, ss, lat, to);
      model(o, aa, bb, er, ev);
      n_chk++;
      if (to) $display("FAIL rand_timeout op=%0d a=%h b=%h got no done want done", o, aa, bb);
      else n_pass++;
      n_chk++;
      if (lat != exp_lat(o, bb))
        $display("FAIL rand_latency op=%0d b=%h got %0d want %0d", o, bb, lat, exp_lat(o, bb));
      else n_pass++;
      n_chk++;
      if (vv !== ev) $display("FAIL rand_v op=%0d a=%h b=%h got %b want %b", o, aa, bb, vv, ev);
      else n_pass++;
      if (!ev || bb == 16'h0) begin
        n_chk++;
        if (r !== er || zz !== (er == 32'h0) || ss !== er[31])
          $display("FAIL rand_rslt op=%0d a=%h b=%h got %h z=%b s=%b want %h z=%b s=%b",
                   o, aa, bb, r, zz, ss, er, (er == 32'h0), er[31]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int waited;
    int pulses;
    op    = MUL_OP;
    a     = 32'h0000_1234;
    b     = 16'h0005;
    cen   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b1) $display("FAIL busy_after_accept got %b want 1", busy);
    else n_pass++;
    repeat (3) tick();
    op    = DIV_OP;
    a     = 32'h0000_0001;
    b     = 16'h0001;
    start = 1'b1;
    tick();
    start  = 1'b0;
    waited = 0;
    while (!done && waited < 100) begin
      tick();
      waited++;
    end
    n_chk++;
    if (!done || rslt !== 32'h0000_5B04)
      $display("FAIL start_while_busy got done=%b rslt=%h want done=1 rslt=00005b04", done, rslt);
    else n_pass++;
    n_chk++;
    if (5 + waited != W + 2) $display("FAIL busy_latency got %0d want %0d", 5 + waited, W + 2);
    else n_pass++;
    pulses = 0;
    repeat (W + 4) begin
      tick();
      if (done || busy) pulses++;
    end
    n_chk++;
    if (pulses != 0) $display("FAIL no_queueing got %0d busy/done cycles want 0", pulses);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    op    = MUL_OP;
    a     = 32'h0000_00FF;
    b     = 16'h0101;
    cen   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || rslt !== 32'h0)
      $display("FAIL reset_mid_op got busy=%b done=%b rslt=%h want 0 0 00000000",
               busy, done, rslt);
    else n_pass++;
    tick();
    rst_n  = 1'b1;
    pulses = 0;
    repeat (W + 6) begin
      tick();
      if (done) pulses++;
    end
    n_chk++;
    if (pulses != 0 || busy !== 1'b0)
      $display("FAIL reset_abort got %0d done pulses busy=%b want 0 0", pulses, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(60, 1'b0);
    test_random(25, 1'b1);
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
